sync_up_counter: RTL and testbench

SYNC_UP_COUNTER -- requirements
Module: sync_up_counter

---
 rtl/sync_up_counter.sv | 51 +++++
 tb/tb_sync_up_counter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sync_up_counter.sv
// sync_up_counter: 4-bit synchronous up/down counter built from T flip-flops.
// All stages share clk; each stage toggles when t is high and every lower
// stage sits at the terminal value for the current direction (all ones when
// counting up, all zeros when counting down). reset is active-low and async.
module sync_up_counter (
  input  logic       t,
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] q,
  output logic [3:0] qb,
  input  logic       M
);

  logic [3:0] tgl;
  logic [3:0] low_ones;
  logic [3:0] low_zeros;

  // Running AND of the lower bits, for both polarities, feeding the toggle terms.
  always_comb begin
    low_ones     = '0;
    low_zeros    = '0;
    low_ones[0]  = q[0];
    low_zeros[0] = ~q[0];
    for (int n = 1; n < 4; n++) begin
      low_ones[n]  = low_ones[n-1] & q[n];
      low_zeros[n] = low_zeros[n-1] & ~q[n];
    end
  end

  // Per-stage toggle enables: stage 0 follows t, higher stages need a full carry/borrow below.
  always_comb begin
    tgl    = '0;
    tgl[0] = t;
    for (int n = 1; n < 4; n++) begin
      tgl[n] = t & (M ? low_zeros[n-1] : low_ones[n-1]);
    end
  end

  // The four T flip-flops, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 4'b0000;
    end else begin
      q <= q ^ tgl;
    end
  end

  // Complement output follows q directly, so it reads 4'b1111 during reset too.
  assign qb = ~q;

endmodule

// File: tb/tb_sync_up_counter.sv
// Testbench for sync_up_counter: vector table, directed reset sequences,
// exhaustive single-step check and randomized run against an arithmetic model.
module tb_sync_up_counter;

  logic       t;
  logic       clk;
  logic       reset;
  logic [3:0] q;
  logic [3:0] qb;
  logic       M;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit t;
    bit m;
    int q;
  } vec_t;

  vec_t tbl[$];

  sync_up_counter dut (
    .t    (t),
    .clk  (clk),
    .reset(reset),
    .q    (q),
    .qb   (qb),
    .M    (M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_next(int cur, bit tt, bit mm);
    if (!tt) return cur;
    if (mm) return (cur + 15) % 16;
    return (cur + 1) % 16;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input int exp);
    n_total++;
    if (act === exp[3:0]) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_q(input string name, input int exp);
    chk({name, "_q"}, q, exp);
    chk({name, "_qb"}, qb, 15 - exp);
  endtask

  // advance one rising edge, then settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit tt, input bit mm, input int qq);
    vec_t v;
    v.t = tt;
    v.m = mm;
    v.q = qq;
    tbl.push_back(v);
  endtask

  task automatic reset_to(input int val);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    t = 1'b1;
    M = 1'b0;
    for (int k = 0; k < val; k++) step();
  endtask

  initial begin
    int mq;
    int exp_q;

    // walk from reset: 20 up, one more up to 5, 8 down, down to 7,
    // hold with M toggling, resume up, flip direction at 10
    for (int i = 1; i <= 20; i++) add(1'b1, 1'b0, i % 16);
    add(1'b1, 1'b0, 5);
    add(1'b1, 1'b1, 4);
    add(1'b1, 1'b1, 3);
    add(1'b1, 1'b1, 2);
    add(1'b1, 1'b1, 1);
    add(1'b1, 1'b1, 0);
    add(1'b1, 1'b1, 15);
    add(1'b1, 1'b1, 14);
    add(1'b1, 1'b1, 13);
    for (int i = 12; i >= 7; i--) add(1'b1, 1'b1, i);
    add(1'b0, 1'b0, 7);
    add(1'b0, 1'b1, 7);
    add(1'b0, 1'b0, 7);
    add(1'b0, 1'b1, 7);
    add(1'b1, 1'b0, 8);
    add(1'b1, 1'b0, 9);
    add(1'b1, 1'b0, 10);
    add(1'b1, 1'b1, 9);

    t = 1'b1;
    M = 1'b0;
    reset = 1'b0;
    #1;
    chk_q("rst_async", 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_q("rst_hold", 0);
    end

    reset = 1'b1;
    foreach (tbl[i]) begin
      t = tbl[i].t;
      M = tbl[i].m;
      step();
      chk_q($sformatf("tbl%0d", i), tbl[i].q);
    end

    // mid-count asynchronous clear at q=9
    reset_to(9);
    chk_q("pre_clear", 9);
    #3;
    reset = 1'b0;
    #1;
    chk_q("mid_clear", 0);
    step();
    chk_q("mid_clear_edge", 0);
    reset = 1'b1;

    // first step after release, down direction
    reset_to(0);
    M = 1'b1;
    step();
    chk_q("release_down", 15);

    // exhaustive single step from every value, both directions
    for (int v = 0; v < 16; v++) begin
      for (int d = 0; d < 2; d++) begin
        reset_to(v);
        M = d[0];
        t = 1'b1;
        step();
        chk_q($sformatf("exh_%0d_m%0d", v, d), model_next(v, 1'b1, d[0]));
      end
    end

    // randomized run with occasional asynchronous clears
    reset_to(0);
    mq = 0;
    for (int k = 0; k < 400; k++) begin
      t = $urandom_range(0, 3) != 0;
      M = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 39) == 0) begin
        #3;
        reset = 1'b0;
        #1;
        mq = 0;
        chk_q("rand_clear", mq);
        step();
        chk_q("rand_clear_edge", mq);
        reset = 1'b1;
      end else begin
        exp_q = model_next(mq, t, M);
        step();
        mq = exp_q;
        chk_q("rand", mq);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
